// File: rtl/expansion_shiftreg_chain.sv
// Scans one daisy chain of 74HC165 inputs and 74HC595 outputs, WIDTH bits long.
// Tick-paced framing FSM with double-buffered images and a trailing latch pulse on stop.
module expansion_shiftreg_chain #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIVIDER   = 100,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             SHIFT_CLK,
  output logic             SHIFT_LOAD,
  output logic             SHIFT_OUT,
  input  logic             SHIFT_IN,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  output logic             frame_done,
  output logic             valid
);

  localparam int unsigned CntW = $clog2(DIVIDER) + 1;
  localparam int unsigned IdxW = $clog2(WIDTH) + 1;
  localparam int unsigned SelW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CntW-1:0] CntReload = CntW'(DIVIDER - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftLo,
    StShiftHi,
    StFlush
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] out_buf_q, out_buf_d;
  logic [WIDTH-1:0] in_buf_q, in_buf_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic             shift_clk_q, shift_clk_d;
  logic             shift_load_q, shift_load_d;
  logic             shift_out_q, shift_out_d;
  logic             frame_done_q, frame_done_d;
  logic             valid_q, valid_d;
  logic             tick;

  // Chain bit position for shift step idx; shared by both images.
  function automatic logic [SelW-1:0] bit_pos(input logic [IdxW-1:0] idx);
    if (MSB_FIRST) begin
      return SelW'(LastIdx - idx);
    end else begin
      return SelW'(idx);
    end
  endfunction

  assign tick  = (cnt_q == '0);
  assign cnt_d = tick ? CntReload : (cnt_q - CntW'(1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    out_buf_d    = out_buf_q;
    in_buf_d     = in_buf_q;
    data_in_d    = data_in_q;
    shift_clk_d  = shift_clk_q;
    shift_load_d = shift_load_q;
    shift_out_d  = shift_out_q;
    frame_done_d = 1'b0;
    valid_d      = valid_q;

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_d      = StLoad;
            shift_load_d = 1'b0;
            out_buf_d    = data_out;
            idx_d        = '0;
          end
        end
        StLoad: begin
          // Rising SHIFT_LOAD also latches the previous frame into the 595s.
          state_d      = StShiftLo;
          shift_load_d = 1'b1;
          shift_out_d  = out_buf_q[bit_pos('0)];
        end
        StShiftLo: begin
          state_d                  = StShiftHi;
          in_buf_d[bit_pos(idx_q)] = SHIFT_IN;
          shift_clk_d              = 1'b1;
        end
        StShiftHi: begin
          shift_clk_d = 1'b0;
          if (idx_q < LastIdx) begin
            state_d     = StShiftLo;
            idx_d       = idx_q + IdxW'(1);
            shift_out_d = out_buf_q[bit_pos(idx_d)];
          end else begin
            data_in_d    = in_buf_q;
            frame_done_d = 1'b1;
            valid_d      = 1'b1;
            shift_load_d = 1'b0;
            if (enable) begin
              state_d   = StLoad;
              out_buf_d = data_out;
              idx_d     = '0;
            end else begin
              state_d = StFlush;
            end
          end
        end
        StFlush: begin
          state_d      = StIdle;
          shift_load_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= CntReload;
      idx_q        <= '0;
      out_buf_q    <= '0;
      in_buf_q     <= '0;
      data_in_q    <= '0;
      shift_clk_q  <= 1'b0;
      shift_load_q <= 1'b1;
      shift_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      out_buf_q    <= out_buf_d;
      in_buf_q     <= in_buf_d;
      data_in_q    <= data_in_d;
      shift_clk_q  <= shift_clk_d;
      shift_load_q <= shift_load_d;
      shift_out_q  <= shift_out_d;
      frame_done_q <= frame_done_d;
      valid_q      <= valid_d;
    end
  end

  assign SHIFT_CLK  = shift_clk_q;
  assign SHIFT_LOAD = shift_load_q;
  assign SHIFT_OUT  = shift_out_q;
  assign data_in    = data_in_q;
  assign frame_done = frame_done_q;
  assign valid      = valid_q;

endmodule

// File: tb/tb_expansion_shiftreg_chain.sv
// Bench for expansion_shiftreg_chain: two chain configurations driven by 165/595 part models,
// with a queue scoreboard for data_in and latch-value checks on the 595 side.
module tb_expansion_shiftreg_chain;

  localparam int unsigned W0 = 16;
  localparam int unsigned D0 = 4;
  localparam int unsigned W1 = 3;
  localparam int unsigned D1 = 1;
  localparam int Per0   = (2 * W0 + 1) * D0;
  localparam int First0 = (2 * W0 + 2) * D0;
  localparam int Per1   = (2 * W1 + 1) * D1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en0, en1;
  logic sclk0, sload0, sout0, sin0, fd0, v0;
  logic sclk1, sload1, sout1, sin1, fd1, v1;
  logic [W0-1:0] dout0, din0, img0;
  logic [W1-1:0] dout1, din1, img1;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int cyc = 0;
  int mode = 0;
  logic per0 = 1'b1;

  expansion_shiftreg_chain #(.WIDTH(W0), .DIVIDER(D0), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .enable(en0), .SHIFT_CLK(sclk0), .SHIFT_LOAD(sload0),
    .SHIFT_OUT(sout0), .SHIFT_IN(sin0), .data_out(dout0), .data_in(din0),
    .frame_done(fd0), .valid(v0)
  );

  expansion_shiftreg_chain #(.WIDTH(W1), .DIVIDER(D1), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1), .SHIFT_CLK(sclk1), .SHIFT_LOAD(sload1),
    .SHIFT_OUT(sout1), .SHIFT_IN(sin1), .data_out(dout1), .data_in(din1),
    .frame_done(fd1), .valid(v1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus: 165 parallel images and 595 output images.
  initial begin
    img0 = 16'hA5C3; dout0 = 16'h1234; img1 = 3'b001; dout1 = 3'b101;
    forever begin
      @(negedge clk);
      if (mode == 0) begin
        if (fd0) dout0 = (dout0 == 16'h1234) ? 16'hBEEF : 16'h1234;
      end else if ($urandom_range(7) == 0) begin
        img0  = 16'($urandom);
        dout0 = 16'($urandom);
      end
      if (mode != 0 && $urandom_range(2) == 0) img1 = 3'($urandom);
      if ($urandom_range(1) == 0) dout1 = 3'($urandom);
    end
  end

  // Part models: 165 loads its image while SHIFT_LOAD is low and shifts on SHIFT_CLK rise;
  // 595 shifts SHIFT_OUT in on SHIFT_CLK rise and latches on SHIFT_LOAD rise.
  logic [W0-1:0] sr165_0 = '0, sr595_0 = '0, img_pend0, snap_pend0, snap_fly0, lat_exp0;
  logic [W1-1:0] sr165_1 = '0, sr595_1 = '0, img_pend1, snap_pend1, snap_fly1, lat_exp1;
  logic [W0-1:0] q_in0[$];
  logic [W1-1:0] q_in1[$];
  assign sin0 = sr165_0[W0-1];
  assign sin1 = sr165_1[0];

  initial begin
    logic pl0, pc0, arm0, fly0, lat_ok0;
    logic pl1, pc1, arm1, fly1, lat_ok1;
    int rises0, rises1;
    pl0 = 1'b1; pc0 = 1'b0; arm0 = 1'b0; fly0 = 1'b0; lat_ok0 = 1'b0; rises0 = 0;
    pl1 = 1'b1; pc1 = 1'b0; arm1 = 1'b0; fly1 = 1'b0; lat_ok1 = 1'b0; rises1 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        q_in0.delete(); arm0 = 1'b0; fly0 = 1'b0; lat_ok0 = 1'b0; rises0 = 0;
        q_in1.delete(); arm1 = 1'b0; fly1 = 1'b0; lat_ok1 = 1'b0; rises1 = 0;
      end else begin
        if (fd0) begin
          check("rises0", rises0, W0);
          if (fly0) begin lat_exp0 = snap_fly0; lat_ok0 = 1'b1; fly0 = 1'b0; end
        end
        if (!sload0 && pl0) snap_pend0 = dout0;
        if (sload0 && !pl0) begin
          sr165_0 = img0; img_pend0 = img0; arm0 = 1'b1;
          if (lat_ok0) begin check("latch0", sr595_0, lat_exp0); lat_ok0 = 1'b0; end
        end
        if (sclk0 && !pc0) begin
          if (arm0) begin
            arm0 = 1'b0; q_in0.push_back(img_pend0);
            snap_fly0 = snap_pend0; fly0 = 1'b1; rises0 = 0;
          end
          rises0++;
          sr165_0 = sr165_0 << 1;
          sr595_0 = {sr595_0[W0-2:0], sout0};
        end

        if (fd1) begin
          check("rises1", rises1, W1);
          if (fly1) begin lat_exp1 = snap_fly1; lat_ok1 = 1'b1; fly1 = 1'b0; end
        end
        if (!sload1 && pl1) snap_pend1 = dout1;
        if (sload1 && !pl1) begin
          sr165_1 = img1; img_pend1 = img1; arm1 = 1'b1;
          if (lat_ok1) begin check("latch1", sr595_1, lat_exp1); lat_ok1 = 1'b0; end
        end
        if (sclk1 && !pc1) begin
          if (arm1) begin
            arm1 = 1'b0; q_in1.push_back(img_pend1);
            snap_fly1 = snap_pend1; fly1 = 1'b1; rises1 = 0;
          end
          rises1++;
          sr165_1 = sr165_1 >> 1;
          sr595_1 = {sout1, sr595_1[W1-1:1]};
        end
      end
      pl0 = sload0; pc0 = sclk0; pl1 = sload1; pc1 = sclk1;
    end
  end

  // Monitor: pops the expected input image whenever a frame is reported.
  int fd0_n = 0;
  initial begin
    int last0, last1;
    logic fd0_prev, fd1_prev;
    last0 = -1; last1 = -1; fd0_prev = 1'b0; fd1_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin last0 = -1; last1 = -1; end
      if (fd0_prev) check("fd0_width", fd0, 1'b0);
      if (fd1_prev) check("fd1_width", fd1, 1'b0);
      if (fd0) begin
        fd0_n++;
        check("valid0", v0, 1'b1);
        if (q_in0.size() == 0) check("din0_extra_frame", 0, 1);
        else check("din0", din0, q_in0.pop_front());
        if (per0 && last0 >= 0) check("period0", cyc - last0, Per0);
        last0 = cyc;
      end
      if (fd1) begin
        check("valid1", v1, 1'b1);
        if (q_in1.size() == 0) check("din1_extra_frame", 0, 1);
        else check("din1", din1, q_in1.pop_front());
        if (last1 >= 0) check("period1", cyc - last1, Per1);
        last1 = cyc;
      end
      fd0_prev = fd0; fd1_prev = fd1;
    end
  end

  task automatic wait_fd0(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd0 && n < budget);
    if (!fd0) check("fd0_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lowcnt, quiet, k, guard, fd_before;
    logic prev;
    rst = 1'b1; en0 = 1'b1; en1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk0", sclk0, 1'b0);
    check("rst_sload0", sload0, 1'b1);
    check("rst_sout0", sout0, 1'b0);
    check("rst_din0", din0, '0);
    check("rst_fd0", fd0, 1'b0);
    check("rst_valid0", v0, 1'b0);
    check("rst_sload1", sload1, 1'b1);
    check("rst_din1", din1, '0);
    @(negedge clk);
    rst = 1'b0;

    // First frame from idle: one extra tick, valid rises with the first pulse.
    repeat (60) @(negedge clk);
    check("valid0_before_first", v0, 1'b0);
    wait_fd0(400, n);
    check("first_latency0", n + 60, First0);

    // Fixed 165 image, alternating output image, enable held.
    repeat (5) wait_fd0(400, n);

    // Randomized images.
    mode = 1;
    repeat (8) wait_fd0(400, n);

    // Drop enable mid-frame: frame completes, single FLUSH latch pulse, then idle.
    wait_fd0(400, n);
    repeat (20) @(negedge clk);
    per0 = 1'b0;
    en0 = 1'b0;
    wait_fd0(400, n);
    check("stop_latency", n + 20, Per0);
    lowcnt = 0;
    while (!sload0 && lowcnt < 50) begin
      lowcnt++;
      @(negedge clk);
    end
    check("flush_low_clks", lowcnt, D0);
    check("idle_sclk0", sclk0, 1'b0);
    check("idle_sload0", sload0, 1'b1);
    quiet = 0;
    repeat (300) begin
      @(negedge clk);
      if (sclk0 || !sload0 || fd0) quiet++;
    end
    check("idle_quiet", quiet, 0);

    // Restart, then reset at bit 7 of the frame.
    en0 = 1'b1;
    guard = 0;
    while (sload0 && guard < 100) begin @(negedge clk); guard++; end
    while (!sload0 && guard < 200) begin @(negedge clk); guard++; end
    k = 0; prev = 1'b0;
    while (k < 8 && guard < 600) begin
      @(negedge clk);
      guard++;
      if (sclk0 && !prev) k++;
      prev = sclk0;
    end
    check("reach_bit7", k, 8);
    fd_before = fd0_n;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_sclk0", sclk0, 1'b0);
    check("mid_rst_sload0", sload0, 1'b1);
    check("mid_rst_sout0", sout0, 1'b0);
    check("mid_rst_din0", din0, '0);
    check("mid_rst_fd0", fd0, 1'b0);
    check("mid_rst_valid0", v0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("no_partial_commit", din0, '0);
    check("no_fd_after_abort", fd0_n, fd_before);
    wait_fd0(400, n);
    check("restart_latency0", n + 100, First0);

    per0 = 1'b1;
    repeat (3) wait_fd0(400, n);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
